// File: rtl/jtbubl_rom_slot.sv
// Graphics ROM responder: serves 32-bit words built from two 16-bit SDRAM reads,
// with a one-entry cache so a repeated word address answers without SDRAM traffic.
module jtbubl_rom_slot #(
  parameter int                  AW       = 18,
  parameter int                  SDRAM_AW = 22,
  parameter logic [SDRAM_AW-1:0] OFFSET   = '0
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                rom_cs,
  input  logic [AW-1:0]       rom_addr,
  output logic [31:0]         rom_data,
  output logic                rom_ok,
  output logic                sdram_req,
  output logic [SDRAM_AW-1:0] sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [15:0]         data_read
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1} state_t;

  state_t              r_state, w_next;
  logic [AW-2:0]       r_tag, r_tag_next;
  logic [AW-2:0]       w_tag_in;
  logic                r_valid, r_req;
  logic [SDRAM_AW-1:0] r_addr;
  logic [31:0]         r_data;
  logic                w_hit;

  // Bit 0 of the client address only picks a half, so it takes no part in the tag
  assign w_tag_in   = rom_addr[AW-1:1];
  assign w_hit      = r_valid && (r_tag == w_tag_in);
  assign rom_ok     = rom_cs && w_hit && (r_state == IDLE);
  assign rom_data   = r_data;
  assign sdram_req  = r_req;
  assign sdram_addr = r_addr;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (rom_cs && !w_hit) w_next = REQ0;
      REQ0:    if (sdram_ack)        w_next = WAIT0;
      WAIT0:   if (data_rdy)         w_next = REQ1;
      REQ1:    if (sdram_ack)        w_next = WAIT1;
      WAIT1:   if (data_rdy)         w_next = IDLE;
      default:                       w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // The cache is invalidated at fetch start, so a fetch that completes after the
  // client moved on can never raise rom_ok for the wrong address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag      <= '0;
      r_tag_next <= '0;
      r_valid    <= 1'b0;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      case (r_state)
        IDLE: if (rom_cs && !w_hit) begin
          r_tag_next <= w_tag_in;
          r_addr     <= OFFSET + SDRAM_AW'({w_tag_in, 1'b0});
          r_req      <= 1'b1;
          r_valid    <= 1'b0;
        end
        REQ0, REQ1: if (sdram_ack) r_req <= 1'b0;
        WAIT0: if (data_rdy) begin
          r_data[15:0] <= data_read;
          r_addr       <= r_addr + 1'b1;
          r_req        <= 1'b1;
        end
        WAIT1: if (data_rdy) begin
          r_data[31:16] <= data_read;
          r_tag         <= r_tag_next;
          r_valid       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtbubl_rom_slot.sv
// Self-checking bench for jtbubl_rom_slot: directed fetches with a scripted SDRAM
// responder; expected words are queued at stimulus time and popped on rom_ok.
module tb_jtbubl_rom_slot;
  localparam int AW = 18;
  localparam int SAW = 22;
  localparam logic [SAW-1:0] OFF = 22'h100000;

  logic clk = 1'b0;
  logic rst, rom_cs, rom_ok, sdram_req, sdram_ack, data_rdy;
  logic [AW-1:0]  rom_addr;
  logic [31:0]    rom_data;
  logic [SAW-1:0] sdram_addr;
  logic [15:0]    data_read;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  jtbubl_rom_slot #(.AW(AW), .SDRAM_AW(SAW), .OFFSET(OFF)) dut (
    .clk(clk), .rst(rst), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok), .sdram_req(sdram_req),
    .sdram_addr(sdram_addr), .sdram_ack(sdram_ack), .data_rdy(data_rdy),
    .data_read(data_read)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    #1;
    while (!sdram_req && n < 20) begin
      tick(); #1; n++;
    end
    chk(tag, 32'(sdram_req), 32'd1);
  endtask

  // Pops the next expected word once rom_ok shows up (bounded)
  task automatic wait_ok(input string tag);
    int n = 0;
    logic [31:0] e;
    #1;
    while (!rom_ok && n < 10) begin
      tick(); #1; n++;
    end
    chk({tag, "_ok"}, 32'(rom_ok), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hX;
    chk({tag, "_data"}, rom_data, e);
  endtask

  // Scripted two-word SDRAM transaction. hook: 1 = change addr in WAIT0,
  // 2 = drop rom_cs in REQ1, 3 = reset in WAIT1 followed by a stray data_rdy.
  task automatic serve_fetch(input logic [SAW-1:0] base, input logic [15:0] d0,
                             input logic [15:0] d1, input int hook,
                             input logic [AW-1:0] haddr);
    wait_req("req0");
    chk("addr0", 32'(sdram_addr), 32'(base));
    chk("ok_busy0", 32'(rom_ok), 32'd0);
    repeat (2) tick();
    // ack with a coincident data_rdy: only the ack may count
    sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 16'hDEAD;
    tick();
    sdram_ack = 1'b0; data_rdy = 1'b0;
    #1 chk("req0_drop", 32'(sdram_req), 32'd0);
    if (hook == 1) rom_addr = haddr;
    tick();
    data_rdy = 1'b1; data_read = d0;
    tick();
    data_rdy = 1'b0;
    wait_req("req1");
    chk("addr1", 32'(sdram_addr), 32'(base + 1'b1));
    chk("ok_busy1", 32'(rom_ok), 32'd0);
    if (hook == 2) rom_cs = 1'b0;
    repeat (2) tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    #1 chk("req1_drop", 32'(sdram_req), 32'd0);
    if (hook == 3) begin
      rst = 1'b1; rom_cs = 1'b0;
      tick();
      rst = 1'b0; data_rdy = 1'b1; data_read = 16'hFFFF;
      tick();
      data_rdy = 1'b0;
      return;
    end
    tick();
    data_rdy = 1'b1; data_read = d1;
    tick();
    data_rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rom_cs = 1'b0; rom_addr = '0;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_ok",   32'(rom_ok),     32'd0);
    chk("rst_data", rom_data,        32'd0);
    chk("rst_req",  32'(sdram_req),  32'd0);
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    // stray data_rdy while idle
    tick();
    data_rdy = 1'b1; data_read = 16'h5555;
    tick();
    data_rdy = 1'b0;
    #1 chk("stray_idle", rom_data, 32'd0);

    // basic miss
    tick();
    rom_cs = 1'b1; rom_addr = 18'h00010;
    exp_q.push_back(32'hABCD1234);
    serve_fetch(OFF + 22'h10, 16'h1234, 16'hABCD, 0, '0);
    #1 chk("t1_ok_now", 32'(rom_ok), 32'd1);
    wait_ok("t1");

    // hits on both halves of the cached word, no SDRAM traffic
    tick();
    rom_addr = 18'h00011;
    exp_q.push_back(32'hABCD1234);
    #1 chk("t2_ok_now", 32'(rom_ok), 32'd1);
    wait_ok("t2");
    repeat (3) tick();
    #1 chk("t2_noreq", 32'(sdram_req), 32'd0);
    rom_addr = 18'h00010;
    #1 chk("t2_ok_back", 32'(rom_ok), 32'd1);

    // address changes mid-fetch: stale fill then a fresh miss
    tick();
    rom_addr = 18'h00050;
    serve_fetch(OFF + 22'h50, 16'h0F0F, 16'hF0F0, 1, 18'h00020);
    #1 chk("t3_no_stale", 32'(rom_ok), 32'd0);
    exp_q.push_back(32'h22222121);
    serve_fetch(OFF + 22'h20, 16'h2121, 16'h2222, 0, '0);
    wait_ok("t3");

    // top of the address range with a non-zero region base
    tick();
    rom_addr = 18'h3FFFE;
    exp_q.push_back(32'h7777EEEE);
    serve_fetch(OFF + 22'h3FFFE, 16'hEEEE, 16'h7777, 0, '0);
    wait_ok("t4");
    rom_addr = 18'h3FFFF;
    #1 chk("t4_odd_hit", 32'(rom_ok), 32'd1);

    // reset while waiting for the second word
    tick();
    rom_addr = 18'h00060;
    serve_fetch(OFF + 22'h60, 16'h6060, 16'h6161, 3, '0);
    #1;
    chk("t5_data", rom_data,        32'd0);
    chk("t5_req",  32'(sdram_req),  32'd0);
    chk("t5_ok",   32'(rom_ok),     32'd0);
    rom_cs = 1'b1;
    #1 chk("t5_miss", 32'(rom_ok), 32'd0);
    exp_q.push_back(32'h61616060);
    serve_fetch(OFF + 22'h60, 16'h6060, 16'h6161, 0, '0);
    wait_ok("t5");

    // client drops rom_cs mid-fetch; fill still lands in the cache
    tick();
    rom_addr = 18'h00070;
    serve_fetch(OFF + 22'h70, 16'h7070, 16'h7171, 2, '0);
    #1 chk("t6_ok_cs_low", 32'(rom_ok), 32'd0);
    repeat (3) tick();
    #1 chk("t6_noreq", 32'(sdram_req), 32'd0);
    rom_cs = 1'b1;
    exp_q.push_back(32'h71717070);
    #1 chk("t6_hit_now", 32'(rom_ok), 32'd1);
    wait_ok("t6");

    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
